// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: Mealy match pulse on the completing bit,
// runtime-loadable pattern/length/overlap mode, and a saturating match counter.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 16,
  parameter int                 CNT_W       = 8,
  parameter int                 RST_LEN     = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b10101011),
  parameter bit                 RST_OVERLAP = 1'b0,
  localparam int                LEN_W       = $clog2(MAX_LEN + 1),
  localparam int                FILL_W      = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [FILL_W-1:0]  fill
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               fill_ok;
  logic               cmp_eq;

  assign cand = {hist_q, in};

  // Only the low len bits of the candidate window take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign mask[gi] = (gi < int'(len_q));
  end

  // fill + 1 >= len avoids the len - 1 underflow when len is zero.
  assign fill_ok = (int'(fill_q) + 1) >= int'(len_q);
  assign cmp_eq  = ((cand ^ pat_q) & mask) == '0;
  assign match   = rstn & in_valid & ~cfg_we & (len_q != '0) & fill_ok & cmp_eq;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;

    if (cfg_we) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovl_d  = cfg_overlap;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = cand[MAX_LEN-2:0];
      if (match && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end

    if (match) begin
      if (cnt_clr) begin
        cnt_d = CNT_W'(1);
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      pat_q  <= RST_PATTERN;
      len_q  <= LEN_W'(RST_LEN);
      ovl_q  <= RST_OVERLAP;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
    end
  end

  assign match_cnt = cnt_q;
  assign fill      = fill_q;

endmodule
